if_prefetch: RTL
================

// Module: if_prefetch
// PURPOSE
//   Instruction-fetch stage feeding the IF/ID boundary. Generates the PC, drives the
//   combinational instruction ROM (ce/addr) and captures the returned word with its PC
//   in a small prefetch FIFO. Presents one registered {pc,inst,valid} per cycle to ID,
//   honours pipeline stall, and flushes/redirects on a taken branch or jump.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC fetched first after reset release
//   DEPTH_LOG2  2              log2 of FIFO depth (depth = 4 entries of {pc,inst})
// PORTS
//   clk              in   1   clock, all state updates on rising edge
//   rst              in   1   asynchronous, active-high reset
//   stall_i          in   1   ID or later stage stalled; ID output register holds
//   branch_flag_i    in   1   taken branch/jump resolved this cycle
//   branch_target_i  in   32  redirect address, sampled when branch_flag_i=1
//   rom_ce_o         out  1   instruction ROM chip enable
//   rom_addr_o       out  32  instruction ROM byte address (= current PC)
//   rom_inst_i       in   32  ROM data, valid combinationally in same cycle
//   id_pc_o          out  32  PC of instruction presented to ID
//   id_inst_o        out  32  instruction presented to ID (NOP when invalid)
//   id_valid_o       out  1   id_pc_o/id_inst_o hold a real fetched instruction
//   misalign_o       out  1   misaligned redirect target seen (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (asserted, async): pc=RESET_PC, rom_ce_o=0, FIFO empty (rd/wr ptr=0,
//     count=0), id_pc_o=0, id_inst_o=NOP (32'h0000_0013), id_valid_o=0, misalign_o=0.
//   - First rising edge after release sets rom_ce_o=1; ce stays 1 until next reset.
//   - rom_addr_o = pc whenever rom_ce_o=1. pc[1:0] is always 2'b00.
//   - Push: when rom_ce_o=1, no branch, and (count<DEPTH or pop this cycle) ->
//     store {pc,rom_inst_i}, pc<=pc+4 (32-bit wrap 0xFFFF_FFFC -> 0). Otherwise
//     pc holds and the ROM word is discarded (refetched next cycle).
//   - Pop: when stall_i=0 and no branch: ID register loads FIFO head, valid=1.
//     If FIFO empty but a push occurs this cycle, bypass: ID loads {pc,rom_inst_i}
//     directly, FIFO unchanged. If empty and no push: ID loads NOP, valid=0.
//   - stall_i=1: ID register holds; push continues until FIFO full.
//   - Simultaneous push+pop at count=DEPTH: legal, count unchanged.
//   - Pointers are DEPTH_LOG2 bits, wrap naturally; count is DEPTH_LOG2+1 bits.
//   - Branch (branch_flag_i=1, priority over stall_i and push): FIFO cleared,
//     pc<=target, ID register <= NOP, valid=0, current ROM word dropped.
//     Latency: target instruction valid on id_* at edge t+2 (t = branch cycle),
//     provided stall_i=0 in cycle t+1.
//   - Back-to-back branches: the later one wins; no stale instruction ever reaches ID.
//   - Reset mid-operation: all state returns to reset values immediately.
// CONFIGURATION
//   IF_ALIGN_CHK_EN defined: branch_target_i[1:0]!=0 sets misalign_o=1 (sticky),
//     fetch halts (no push, pc held at target&~3, id_valid_o=0) until the next
//     aligned branch, which clears misalign_o and redirects normally.
//   Not defined: target low two bits forced to 2'b00, misalign_o tied 0.
// TESTING
//   1. Reset, release, no stall, ROM = inst==addr -> id_pc_o 0,4,8,.. one per cycle,
//      first valid at 2nd edge after release, id_inst_o==id_pc_o.
//   2. Hold stall_i=1 for 8 cycles -> id_* frozen, FIFO fills to 4, pc stops at
//      last_pc+16; release -> 4 buffered then sequential PCs, none skipped/duplicated.
//   3. branch_flag_i=1 target 0x100 with FIFO full -> next edge id_valid_o=0, edge
//      t+2 id_pc_o=0x100, then 0x104; no pre-branch PC appears afterwards.
//   4. Branch while stall_i=1 -> flush still occurs, id_valid_o=0 next edge.
//   5. pc=0xFFFF_FFF8 run freely -> id_pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//   6. Target 0x102: with IF_ALIGN_CHK_EN misalign_o=1, id_valid_o stays 0; then
//      target 0x200 clears it. Without macro: fetch proceeds at 0x100.

Source files
------------

// File: rtl/if_prefetch.sv
// if_prefetch: PC generation, ROM fetch, 4-entry prefetch FIFO and registered IF/ID output.
// Define IF_ALIGN_CHK_EN to halt fetch and flag misalign_o on a misaligned redirect target.
module if_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        misalign_o
);
  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  logic [31:0]           pc_q, id_pc_q, id_inst_q;
  logic                  ce_q, id_valid_q, mis_q, mis_d;
  logic [DEPTH_LOG2-1:0] rd_q, wr_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic [31:0]           fpc_q [DEPTH];
  logic [31:0]           finst_q [DEPTH];
  logic                  full, empty, pop_ok, push, deq, wr_en;
  always_comb begin
    full   = cnt_q == (DEPTH_LOG2+1)'(DEPTH);
    empty  = cnt_q == '0;
    pop_ok = !stall_i && !branch_flag_i;
    push   = ce_q && !mis_q && !branch_flag_i && (!full || pop_ok);
    deq    = pop_ok && !empty;
    // an empty FIFO with a pop forwards the ROM word straight to ID instead of storing it
    wr_en  = push && !(pop_ok && empty);
`ifdef IF_ALIGN_CHK_EN
    mis_d  = branch_flag_i ? (branch_target_i[1:0] != 2'b00) : mis_q;
`else
    mis_d  = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      mis_q      <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP;
      id_valid_q <= 1'b0;
    end else begin
      ce_q  <= 1'b1;
      mis_q <= mis_d;
      if (branch_flag_i) begin
        pc_q       <= {branch_target_i[31:2], 2'b00};
        rd_q       <= '0;
        wr_q       <= '0;
        cnt_q      <= '0;
        id_inst_q  <= NOP;
        id_valid_q <= 1'b0;
      end else begin
        if (push) pc_q <= pc_q + 32'd4;
        if (wr_en) wr_q <= wr_q + 1'b1;
        if (deq) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + (DEPTH_LOG2+1)'(wr_en) - (DEPTH_LOG2+1)'(deq);
        if (pop_ok) begin
          id_valid_q <= deq || push;
          id_pc_q    <= deq ? fpc_q[rd_q] : push ? pc_q : id_pc_q;
          id_inst_q  <= deq ? finst_q[rd_q] : push ? rom_inst_i : NOP;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fpc_q[wr_q]   <= pc_q;
      finst_q[wr_q] <= rom_inst_i;
    end
  end
  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;
  assign misalign_o = mis_q;
endmodule
